// File: rtl/proj_sched_pkg.sv
// Shared types and constants for the MVP projection scheduler.
package proj_sched_pkg;

    localparam int          COORD_W        = 16;
    localparam logic [11:0] DEF_ANGLE_STEP = 12'h004;
    localparam logic [11:0] DEF_ANGLE_WRAP = 12'h649;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        SETTLE,
        OUTPUT,
        DONE
    } sched_state_t;

    typedef logic [2:0][2:0][COORD_W-1:0] tri3d_t;
    typedef logic [2:0][1:0][9:0]         tri2d_t;

endpackage

// File: rtl/angle_accumulator.sv
// Per-frame rotation angle: registered modular add of STEP, kept in [0, WRAP).
module angle_accumulator
    import proj_sched_pkg::*;
#(
    parameter int            W    = 12,
    parameter logic [W-1:0]  STEP = W'(DEF_ANGLE_STEP),
    parameter logic [W-1:0]  WRAP = W'(DEF_ANGLE_WRAP)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en_i,
    output logic [W-1:0] angle_o
);

    logic [W-1:0] angle_q;
    logic [W-1:0] angle_d;
    logic [W:0]   sum_raw;
    logic [W:0]   sum_wrapped;

    // One extra bit so the sum can exceed WRAP without overflowing before the compare.
    always_comb begin
        sum_raw     = {1'b0, angle_q} + {1'b0, STEP};
        sum_wrapped = (sum_raw >= {1'b0, WRAP}) ? (sum_raw - {1'b0, WRAP}) : sum_raw;
        angle_d     = en_i ? sum_wrapped[W-1:0] : angle_q;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            angle_q <= '0;
        end else begin
            angle_q <= angle_d;
        end
    end

    assign angle_o = angle_q;

endmodule

// File: rtl/projection_scheduler.sv
// Walks one frame of triangles through the combinational projection datapath and
// hands each projected triangle to the rasterizer over valid/ready.
module projection_scheduler
    import proj_sched_pkg::*;
#(
    parameter int                     WI         = 8,
    parameter int                     WF         = 8,
    parameter int                     WIIA       = 4,
    parameter int                     WIFA       = 8,
    parameter int                     NUM_TRI    = 12,
    parameter int                     ADDR_W     = 8,
    parameter int                     SETTLE_CYC = 2,
    parameter logic [WIIA+WIFA-1:0]   ANGLE_STEP = 12'h004,
    parameter logic [WIIA+WIFA-1:0]   ANGLE_WRAP = DEF_ANGLE_WRAP
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     frame_start,
    output logic                     tri_rd,
    output logic [ADDR_W-1:0]        tri_addr,
    input  logic [9*(WI+WF)-1:0]     tri_data,
    output logic [9*(WI+WF)-1:0]     cal_triangle,
    output logic [WIIA+WIFA-1:0]     cal_angle,
    input  tri2d_t                   cal_proj,
    output tri2d_t                   out_tri,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     busy,
    output logic                     frame_done,
    output logic                     overrun
);

    localparam int                CNT_W       = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [ADDR_W-1:0] IDX_LAST    = ADDR_W'(NUM_TRI - 1);

    sched_state_t                state_q;
    logic [ADDR_W-1:0]           idx_q;
    logic [CNT_W-1:0]            settle_q;
    logic [9*(WI+WF)-1:0]        cal_tri_q;
    tri2d_t                      out_tri_q;
    logic                        tri_rd_q;
    logic                        out_valid_q;
    logic                        busy_q;
    logic                        frame_done_q;
    logic                        overrun_q;

    // NOTE: the datapath registers are reset too, so an aborted frame leaves no stale triangle visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            settle_q     <= '0;
            cal_tri_q    <= '0;
            out_tri_q    <= '0;
            tri_rd_q     <= 1'b0;
            out_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            overrun_q <= frame_start && (state_q != IDLE);
            unique case (state_q)
                IDLE: begin
                    if (frame_start) begin
                        idx_q    <= '0;
                        tri_rd_q <= 1'b1;
                        busy_q   <= 1'b1;
                        state_q  <= FETCH;
                    end
                end
                FETCH: begin
                    tri_rd_q <= 1'b0;
                    state_q  <= LOAD;
                end
                LOAD: begin
                    cal_tri_q <= tri_data;
                    settle_q  <= '0;
                    state_q   <= SETTLE;
                end
                SETTLE: begin
                    if (settle_q == SETTLE_LAST) begin
                        out_tri_q   <= cal_proj;
                        out_valid_q <= 1'b1;
                        state_q     <= OUTPUT;
                    end else begin
                        settle_q <= settle_q + 1'b1;
                    end
                end
                OUTPUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (idx_q == IDX_LAST) begin
                            frame_done_q <= 1'b1;
                            state_q      <= DONE;
                        end else begin
                            idx_q    <= idx_q + 1'b1;
                            tri_rd_q <= 1'b1;
                            state_q  <= FETCH;
                        end
                    end
                end
                DONE: begin
                    frame_done_q <= 1'b0;
                    busy_q       <= 1'b0;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    angle_accumulator #(
        .W    (WIIA + WIFA),
        .STEP (ANGLE_STEP),
        .WRAP (ANGLE_WRAP)
    ) u_angle (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (state_q == DONE),
        .angle_o (cal_angle)
    );

    assign tri_rd       = tri_rd_q;
    assign tri_addr     = idx_q;
    assign cal_triangle = cal_tri_q;
    assign out_tri      = out_tri_q;
    assign out_valid    = out_valid_q;
    assign busy         = busy_q;
    assign frame_done   = frame_done_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_projection_scheduler.sv
// Scoreboard bench for projection_scheduler: a 3-triangle instance and a 4-cycle-settle instance.
`timescale 1ns/1ps
module tb_projection_scheduler;
    import proj_sched_pkg::*;

    localparam int ADDR_W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic              frame_start, tri_rd, out_valid, out_ready, busy, frame_done, overrun;
    logic [ADDR_W-1:0] tri_addr;
    tri3d_t            tri_data, cal_triangle;
    logic [11:0]       cal_angle;
    tri2d_t            cal_proj, out_tri;

    logic              s_frame_start, s_tri_rd, s_out_valid, s_out_ready, s_busy, s_frame_done, s_overrun;
    logic [ADDR_W-1:0] s_tri_addr;
    tri3d_t            s_tri_data, s_cal_triangle;
    logic [11:0]       s_cal_angle;
    tri2d_t            s_cal_proj, s_out_tri;

    int     total = 0;
    int     bad   = 0;
    tri2d_t exp_q[$];
    tri2d_t s_exp_q[$];

    projection_scheduler #(.NUM_TRI(3), .SETTLE_CYC(2)) dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .tri_rd(tri_rd), .tri_addr(tri_addr),
        .tri_data(tri_data), .cal_triangle(cal_triangle), .cal_angle(cal_angle), .cal_proj(cal_proj),
        .out_tri(out_tri), .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
        .frame_done(frame_done), .overrun(overrun)
    );

    projection_scheduler #(.NUM_TRI(1), .SETTLE_CYC(4)) dut_s (
        .clk(clk), .rst_n(rst_n), .frame_start(s_frame_start), .tri_rd(s_tri_rd), .tri_addr(s_tri_addr),
        .tri_data(s_tri_data), .cal_triangle(s_cal_triangle), .cal_angle(s_cal_angle), .cal_proj(s_cal_proj),
        .out_tri(s_out_tri), .out_valid(s_out_valid), .out_ready(s_out_ready), .busy(s_busy),
        .frame_done(s_frame_done), .overrun(s_overrun)
    );

    function automatic tri3d_t mem_word(input logic [ADDR_W-1:0] a);
        tri3d_t t;
        for (int v = 0; v < 3; v++)
            for (int c = 0; c < 3; c++)
                t[v][c] = {a, 4'(v), 4'(c)};
        return t;
    endfunction

    function automatic tri2d_t proj_fn(input tri3d_t t);
        tri2d_t p;
        for (int v = 0; v < 3; v++)
            for (int c = 0; c < 2; c++)
                p[v][c] = t[v][c][15:6] + t[v][2][9:0] + 10'(v * 3 + c);
        return p;
    endfunction

    function automatic tri3d_t junk3d();
        tri3d_t t;
        for (int v = 0; v < 3; v++)
            for (int c = 0; c < 3; c++)
                t[v][c] = 16'($urandom());
        return t;
    endfunction

    function automatic tri2d_t junk2d();
        tri2d_t p;
        for (int v = 0; v < 3; v++)
            for (int c = 0; c < 2; c++)
                p[v][c] = 10'($urandom());
        return p;
    endfunction

    // Projection stand-in and 1-cycle-latency triangle memory; each read pushes its expected result.
    assign cal_proj = proj_fn(cal_triangle);

    always @(posedge clk) begin
        if (tri_rd) begin
            tri_data <= mem_word(tri_addr);
            exp_q.push_back(proj_fn(mem_word(tri_addr)));
        end else begin
            tri_data <= junk3d();
        end
    end

    task automatic run_frame(input int stall_tri, input int stall_len, input bit inject_ovr,
                             output int first_valid, output int done_cyc, output int last_hs,
                             output int n_hs, output int n_ovr, output int rd_in_stall,
                             output int rd_mask, output int n_rd, output bit angle_moved);
        tri2d_t      held;
        tri2d_t      exp;
        int          stall_n;
        int          cyc;
        bit          in_stall;
        bit          done_seen;
        logic [11:0] angle0;
        first_valid = -1; done_cyc = -1; last_hs = -1; n_hs = 0; n_ovr = 0;
        rd_in_stall = 0; rd_mask = 0; n_rd = 0; stall_n = 0; in_stall = 0; done_seen = 0;
        angle_moved = 0;
        held = '0;
        @(negedge clk);
        angle0 = cal_angle;
        frame_start = 1'b1;
        out_ready   = 1'b1;
        @(negedge clk);
        cyc = 1;
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL busy_in_frame: got %b want 1", busy);
        end
        while (cyc < 400 && !done_seen) begin
            frame_start = 1'b0;
            if (overrun) n_ovr++;
            if (tri_rd) begin
                n_rd++;
                rd_mask |= (1 << tri_addr);
                if (in_stall) rd_in_stall++;
            end
            if (!frame_done && cal_angle !== angle0) angle_moved = 1;
            if (inject_ovr && cyc == 3) frame_start = 1'b1;
            if (out_valid) begin
                if (first_valid < 0) first_valid = cyc;
                if (n_hs == stall_tri && stall_n < stall_len) begin
                    if (stall_n == 0) begin
                        held = out_tri;
                    end else begin
                        total++;
                        if (out_tri !== held) begin
                            bad++;
                            $display("FAIL stall_hold cyc=%0d: got %h want %h", cyc, out_tri, held);
                        end
                    end
                    stall_n++;
                    in_stall  = 1;
                    out_ready = 1'b0;
                end else begin
                    if (in_stall) begin
                        total++;
                        if (out_tri !== held) begin
                            bad++;
                            $display("FAIL stall_release cyc=%0d: got %h want %h", cyc, out_tri, held);
                        end
                    end
                    in_stall  = 0;
                    out_ready = 1'b1;
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL sb_empty cyc=%0d: got %h want none", cyc, out_tri);
                    end else begin
                        exp = exp_q.pop_front();
                        if (out_tri !== exp) begin
                            bad++;
                            $display("FAIL sb_data hs=%0d: got %h want %h", n_hs, out_tri, exp);
                        end
                    end
                    n_hs++;
                    last_hs = cyc;
                end
            end else begin
                out_ready = 1'b1;
            end
            if (frame_done) begin
                done_cyc  = cyc;
                done_seen = 1;
                if (inject_ovr) frame_start = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        frame_start = 1'b0;
        if (overrun) n_ovr++;
        if (!done_seen) begin
            total++;
            bad++;
            $display("FAIL frame_timeout: got no frame_done want frame_done within 400 cycles");
        end
    endtask

    task automatic fast_frame();
        int n;
        @(negedge clk);
        frame_start = 1'b1;
        out_ready   = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        n = 0;
        while (!frame_done && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!frame_done) begin
            total++;
            bad++;
            $display("FAIL fast_frame_timeout: got no frame_done want frame_done");
        end
        @(negedge clk);
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        frame_start = 1'b0; out_ready = 1'b1;
        s_frame_start = 1'b0; s_out_ready = 1'b1; s_tri_data = '0; s_cal_proj = '0;
        repeat (3) @(negedge clk);
        total++;
        if ({tri_rd, out_valid, busy, frame_done, overrun} !== 5'b0 || tri_addr !== '0) begin
            bad++;
            $display("FAIL reset_ctrl: got %b addr=%h want 00000 addr=00",
                     {tri_rd, out_valid, busy, frame_done, overrun}, tri_addr);
        end
        total++;
        if (cal_triangle !== '0 || out_tri !== '0 || cal_angle !== 12'h000) begin
            bad++;
            $display("FAIL reset_data: got tri=%h out=%h ang=%h want zeros", cal_triangle, out_tri, cal_angle);
        end
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: got busy=%b valid=%b want 0 0", busy, out_valid);
        end
        exp_q.delete();
    endtask

    task automatic test_full_frame();
        int fv, dc, lh, nh, no, ris, rm, nr;
        bit am;
        run_frame(-1, 0, 1'b0, fv, dc, lh, nh, no, ris, rm, nr, am);
        total++;
        if (fv !== 5) begin bad++; $display("FAIL first_valid: got %0d want 5", fv); end
        total++;
        if (nh !== 3 || nr !== 3 || rm !== 7) begin
            bad++;
            $display("FAIL reads_handshakes: got hs=%0d rd=%0d mask=%0h want 3 3 7", nh, nr, rm);
        end
        total++;
        if (dc !== lh + 1 || dc !== 16) begin
            bad++;
            $display("FAIL done_timing: got %0d want %0d (16)", dc, lh + 1);
        end
        total++;
        if (busy !== 1'b0 || frame_done !== 1'b0) begin
            bad++;
            $display("FAIL after_done: got busy=%b done=%b want 0 0", busy, frame_done);
        end
        total++;
        if (cal_angle !== 12'h004 || am) begin
            bad++;
            $display("FAIL angle_frame1: got %h moved=%b want 004 0", cal_angle, am);
        end
        total++;
        if (no !== 0) begin bad++; $display("FAIL spurious_overrun: got %0d want 0", no); end
    endtask

    task automatic test_backpressure();
        int fv, dc, lh, nh, no, ris, rm, nr;
        bit am;
        run_frame(1, 7, 1'b0, fv, dc, lh, nh, no, ris, rm, nr, am);
        total++;
        if (nh !== 3 || nr !== 3 || ris !== 0) begin
            bad++;
            $display("FAIL bp_counts: got hs=%0d rd=%0d rd_in_stall=%0d want 3 3 0", nh, nr, ris);
        end
        total++;
        if (dc !== 23) begin bad++; $display("FAIL bp_done_cyc: got %0d want 23", dc); end
        total++;
        if (cal_angle !== 12'h008) begin bad++; $display("FAIL bp_angle: got %h want 008", cal_angle); end
        total++;
        if (exp_q.size() !== 0) begin bad++; $display("FAIL bp_leftover: got %0d want 0", exp_q.size()); end
    endtask

    task automatic test_overrun();
        int fv, dc, lh, nh, no, ris, rm, nr;
        bit am;
        run_frame(-1, 0, 1'b1, fv, dc, lh, nh, no, ris, rm, nr, am);
        total++;
        if (no !== 2) begin bad++; $display("FAIL overrun_pulses: got %0d want 2", no); end
        total++;
        if (nh !== 3 || dc !== 16) begin
            bad++;
            $display("FAIL overrun_frame: got hs=%0d done=%0d want 3 16", nh, dc);
        end
        repeat (3) @(negedge clk);
        total++;
        if (cal_angle !== 12'h00C || busy !== 1'b0) begin
            bad++;
            $display("FAIL overrun_angle: got ang=%h busy=%b want 00c 0", cal_angle, busy);
        end
    endtask

    task automatic test_reset_mid_frame();
        int n;
        bit done_seen;
        @(negedge clk);
        frame_start = 1'b1;
        out_ready   = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        n = 0;
        while (!(out_valid && tri_addr == 8'd1) && n < 100) begin
            @(negedge clk);
            n++;
        end
        out_ready = 1'b0;
        total++;
        if (!(out_valid && tri_addr == 8'd1)) begin
            bad++;
            $display("FAIL mid_reach: got valid=%b addr=%h want 1 01", out_valid, tri_addr);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({tri_rd, out_valid, busy, frame_done, overrun} !== 5'b0 || tri_addr !== '0) begin
            bad++;
            $display("FAIL mid_reset_ctrl: got %b addr=%h want 00000 addr=00",
                     {tri_rd, out_valid, busy, frame_done, overrun}, tri_addr);
        end
        total++;
        if (cal_triangle !== '0 || out_tri !== '0 || cal_angle !== 12'h000) begin
            bad++;
            $display("FAIL mid_reset_data: got tri=%h out=%h ang=%h want zeros", cal_triangle, out_tri, cal_angle);
        end
        repeat (2) @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        done_seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (frame_done || busy) done_seen = 1;
        end
        total++;
        if (done_seen || cal_angle !== 12'h000) begin
            bad++;
            $display("FAIL mid_after: got activity=%b ang=%h want 0 000", done_seen, cal_angle);
        end
        exp_q.delete();
    endtask

    task automatic test_angle_wrap();
        for (int f = 0; f < 402; f++) fast_frame();
        total++;
        if (cal_angle !== 12'h648) begin bad++; $display("FAIL wrap_preset: got %h want 648", cal_angle); end
        fast_frame();
        total++;
        if (cal_angle !== 12'h003) begin bad++; $display("FAIL wrap_result: got %h want 003", cal_angle); end
    endtask

    task automatic test_settle();
        tri2d_t vals[4];
        tri2d_t exp;
        int     n_valid;
        for (int i = 0; i < 4; i++) vals[i] = junk2d();
        n_valid = 0;
        @(negedge clk);
        s_frame_start = 1'b1;
        s_out_ready   = 1'b1;
        s_cal_proj    = junk2d();
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            s_frame_start = 1'b0;
            if (s_out_valid) begin
                n_valid++;
                total++;
                if (k != 7) begin bad++; $display("FAIL settle_valid_cyc: got %0d want 7", k); end
                total++;
                if (s_exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL settle_sb_empty: got %h want none", s_out_tri);
                end else begin
                    exp = s_exp_q.pop_front();
                    if (s_out_tri !== exp) begin
                        bad++;
                        $display("FAIL settle_capture: got %h want %h", s_out_tri, exp);
                    end
                end
            end
            if (k == 8) begin
                total++;
                if (s_frame_done !== 1'b1) begin bad++; $display("FAIL settle_done: got %b want 1", s_frame_done); end
            end
            if (k >= 3 && k <= 6) s_cal_proj = vals[k-3];
            else                  s_cal_proj = junk2d();
            if (k == 6) s_exp_q.push_back(vals[3]);
        end
        total++;
        if (n_valid != 1) begin bad++; $display("FAIL settle_valid_count: got %0d want 1", n_valid); end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_backpressure();
        test_overrun();
        test_reset_mid_frame();
        test_angle_wrap();
        test_settle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/projection_scheduler.md
# projection_scheduler

Sequences the combinational MVP projection datapath over one frame's worth of triangles. On each frame start it reads every triangle from a 1-cycle-latency triangle memory and holds it stable at the projection datapath inputs. After a fixed settle time it captures the projected screen-space triangle and hands it to the rasterizer over a valid/ready handshake. It owns the per-frame rotation angle, advancing it once per completed frame with wrap at 2π.

## Interface
- WI, 8: integer bits of vertex coordinates
- WF, 8: fraction bits of vertex coordinates
- WIIA, 4: integer bits of angle
- WIFA, 8: fraction bits of angle
- NUM_TRI, 12: triangles per frame (≥1)
- ADDR_W, 8: triangle memory address width (2^ADDR_W ≥ NUM_TRI)
- SETTLE_CYC, 2: cycles the datapath inputs are held before capture (≥1)
- ANGLE_STEP, 12'h004: angle increment per frame
- ANGLE_WRAP, 12'h649: 2π in angle format; angle kept in [0, ANGLE_WRAP)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- frame_start  in  1  single-cycle pulse, begin a frame
- tri_rd  out  1  triangle memory read strobe
- tri_addr  out  ADDR_W  triangle index being read
- tri_data  in  9*(WI+WF)  [2:0][2:0] vertex/xyz; valid the cycle after tri_rd
- cal_triangle  out  9*(WI+WF)  registered triangle to projection datapath
- cal_angle  out  WIIA+WIFA  registered angle to projection datapath
- cal_proj  in  60  [2:0][1:0][9:0] projected triangle from datapath
- out_tri  out  60  captured projected triangle
- out_valid  out  1  out_tri valid
- out_ready  in  1  rasterizer accepts
- busy  out  1  high in every state except IDLE
- frame_done  out  1  one-cycle pulse at end of frame
- overrun  out  1  one-cycle pulse when frame_start arrives while busy

## Operation
- States: IDLE, FETCH, LOAD, SETTLE, OUTPUT, DONE.
- IDLE: on frame_start, clear idx to 0 and go to FETCH.
- FETCH: tri_rd=1, tri_addr=idx; go to LOAD.
- LOAD: register tri_data into cal_triangle; clear the settle counter; go to SETTLE.
- SETTLE: count to SETTLE_CYC. In the last SETTLE cycle, register cal_proj into out_tri, then go to OUTPUT.
- OUTPUT: out_valid=1 and out_tri held stable until out_valid&&out_ready.
  - On handshake with idx==NUM_TRI-1, go to DONE.
  - On handshake otherwise, idx+1 and go to FETCH.
- DONE: frame_done=1 for one cycle and update the angle; go to IDLE.
- Angle update: next = cal_angle+ANGLE_STEP; if next ≥ ANGLE_WRAP, subtract ANGLE_WRAP. Unsigned arithmetic, one bit wider internally.
- cal_angle changes only in DONE, so every triangle of a frame is projected at the same angle.
- frame_start in any state other than IDLE is ignored and pulses overrun. This includes DONE.
- tri_rd is high only in FETCH. tri_addr holds idx in all states.

## Timing
- Reset values:
  - State IDLE, idx 0, settle counter 0.
  - cal_triangle 0, cal_angle 0, out_tri 0.
  - tri_rd, tri_addr, out_valid, busy, frame_done and overrun all 0.
- Latency:
  - frame_start at cycle 0: FETCH at cycle 1, LOAD at 2, SETTLE at 3..2+SETTLE_CYC.
  - First out_valid at cycle 3+SETTLE_CYC.
- Per-triangle cost is 3+SETTLE_CYC cycles plus backpressure stall. Default is 5 cycles, so 60 cycles per frame with out_ready held high.
- frame_done occurs the cycle after the last handshake. busy drops the following cycle.
- Backpressure: out_tri and out_valid are stable while out_ready=0. No triangle is dropped or duplicated.
- Asynchronous reset mid-frame: all outputs return immediately to their reset values and the partial frame is abandoned. No frame_done pulse is produced for it.
- frame_start in the same cycle that DONE is active: ignored, overrun pulses. A new frame needs frame_start while in IDLE.

## Structure
- Package proj_sched_pkg holds:
  - state enum sched_state_t
  - tri3d_t, a [2:0][2:0][WI+WF-1:0] vector
  - tri2d_t, a [2:0][1:0][9:0] vector
  - default ANGLE_WRAP constant
- Natural sub-module: angle_accumulator, a registered modular add with an enable driven by DONE. The FSM, index counter and settle counter stay in projection_scheduler.

## Test plan
- Reset: assert rst_n=0 mid-OUTPUT -> all outputs 0 that same cycle; after release busy=0, cal_angle=0.
- Full frame, NUM_TRI=3, out_ready=1, memory returns index-tagged data -> tri_addr reads 0,1,2 once each; out_tri matches the model for each index; out_valid first seen 5 cycles after frame_start; frame_done 1 cycle after the third handshake; cal_angle=0x004.
- Backpressure: hold out_ready=0 for 7 cycles on triangle 1 -> out_tri stable, single handshake, no tri_rd during the stall.
- Angle wrap: preset via 402 frames with ANGLE_STEP=4 (0x648) -> next frame's cal_angle=0x003 (0x64C−0x649).
- Overrun: pulse frame_start in SETTLE and in DONE -> overrun pulses 1 cycle each; the frame completes unchanged; the frame count is not incremented.
- Settle: SETTLE_CYC=4, change cal_proj during the first 3 SETTLE cycles -> out_tri equals the value present in the 4th.
